// File: rtl/word_unpack.sv
// Word-to-byte unpacker: buffers {swap, keep, data} words in a small FIFO and replays the
// kept bytes of each word, in the selected order, over a valid/ready byte interface.
module word_unpack #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    input  logic [1:0]       in_keep_i,
    input  logic             in_swap_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_data_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] byte_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StFirst  = 2'd1;
    localparam logic [1:0] StSecond = 2'd2;

    logic [18:0]      mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic             fifo_empty, push, pop, fire, do_fetch;
    logic [18:0]      head;
    logic             head_swap;
    logic [1:0]       head_keep;
    logic [7:0]       head_hi, head_lo;
    logic             fetch_valid, fetch_two;
    logic [7:0]       fetch_first, fetch_second;

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [7:0]       second_q, second_d;
    logic             has_second_q, has_second_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = in_valid_i && in_ready_q;
    assign fire       = out_valid_q && out_ready_i;

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_swap = head[18];
    assign head_keep = head[17:16];
    assign head_hi   = head[15:8];
    assign head_lo   = head[7:0];

    // First/second byte of the head entry; keep==00 entries are dropped on fetch.
    assign fetch_valid  = !fifo_empty && (head_keep != 2'b00);
    assign fetch_two    = (head_keep == 2'b11);
    assign fetch_first  = fetch_two ? (head_swap ? head_lo : head_hi)
                                    : (head_keep[1] ? head_hi : head_lo);
    assign fetch_second = head_swap ? head_hi : head_lo;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        second_d     = second_q;
        has_second_d = has_second_q;
        pop          = 1'b0;
        do_fetch     = 1'b0;

        case (state_q)
            StIdle:   do_fetch = 1'b1;
            StFirst: begin
                if (out_ready_i) begin
                    if (has_second_q) begin
                        out_data_d = second_q;
                        out_last_d = 1'b1;
                        state_d    = StSecond;
                    end else begin
                        do_fetch = 1'b1;
                    end
                end
            end
            StSecond: if (out_ready_i) do_fetch = 1'b1;
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase

        if (do_fetch) begin
            pop = !fifo_empty;
            if (fetch_valid) begin
                out_valid_d  = 1'b1;
                out_data_d   = fetch_first;
                out_last_d   = !fetch_two;
                second_d     = fetch_second;
                has_second_d = fetch_two;
                state_d      = StFirst;
            end else begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        end
    end

    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    // Registered ready: a pop while full only frees a slot from the next cycle on.
    assign in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                          (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    assign byte_cnt_d = byte_cnt_q + {{(CNT_W-1){1'b0}}, fire};

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_swap_i, in_keep_i, in_data_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            second_q     <= '0;
            has_second_q <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_ready_q   <= in_ready_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            second_q     <= second_d;
            has_second_q <= has_second_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign byte_cnt_o  = byte_cnt_q;

endmodule

// File: tb/tb_word_unpack.sv
// Bench for word_unpack: directed scenarios plus random traffic, checked against a
// byte-queue model of the kept bytes and a handshake counter.
module tb_word_unpack;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic [1:0]  in_keep_i;
    logic        in_swap_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic [15:0] byte_cnt_o;

    word_unpack #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_keep_i   (in_keep_i),
        .in_swap_i   (in_swap_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .byte_cnt_o  (byte_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [8:0]  exp_q[$];          // {last, data} in emission order
    logic [15:0] model_cnt = '0;
    logic        stall_q   = 1'b0;
    logic [7:0]  held_data;
    logic        held_last;
    bit          done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: list the word's bytes in emission order, keep only the kept ones.
    task automatic model_push(input logic [15:0] d, input logic [1:0] k, input logic s);
        logic [7:0] b[2];
        logic       kb[2];
        logic [7:0] kept[$];
        b[0] = d[15:8]; kb[0] = k[1];
        b[1] = d[7:0];  kb[1] = k[0];
        if (s) begin
            b[0] = d[7:0];  kb[0] = k[0];
            b[1] = d[15:8]; kb[1] = k[1];
        end
        for (int i = 0; i < 2; i++) if (kb[i]) kept.push_back(b[i]);
        for (int i = 0; i < kept.size(); i++)
            exp_q.push_back({(i == kept.size() - 1) ? 1'b1 : 1'b0, kept[i]});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_cnt = '0;
            stall_q   = 1'b0;
        end else begin
            logic [8:0] e;
            check_eq("byte_cnt", byte_cnt_o, model_cnt);
            if (stall_q) begin
                check_eq("stall_valid", out_valid_o, 1);
                check_eq("stall_data", out_data_o, held_data);
                check_eq("stall_last", out_last_o, held_last);
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_byte", out_valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data_o, e[7:0]);
                    check_eq("out_last", out_last_o, e[8]);
                end
                model_cnt = model_cnt + 16'd1;
            end
            stall_q   = out_valid_o && !out_ready_i;
            held_data = out_data_o;
            held_last = out_last_o;
            if (in_valid_i && in_ready_o) model_push(in_data_i, in_keep_i, in_swap_i);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_word(input logic [15:0] d, input logic [1:0] k, input logic s);
        int w = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_keep_i  = k;
        in_swap_i  = s;
        @(negedge clk);
        while (!in_ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready_o) check_eq("push_timeout", in_ready_o, 1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        out_ready_i = 1'b1;
        while ((exp_q.size() != 0 || out_valid_o) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    // Cycles from the first valid byte until n handshakes; no bubbles means exactly n.
    task automatic measure_run(input int n, input string tag);
        int w = 0;
        int cyc = 0;
        int hs = 0;
        @(negedge clk);
        while (!out_valid_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid_o) begin
            check_eq({tag, "_start"}, out_valid_o, 1);
        end else begin
            while (hs < n && cyc < 4 * n) begin
                cyc++;
                if (out_valid_o && out_ready_i) hs++;
                if (hs < n) @(negedge clk);
            end
            check_eq(tag, cyc, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_keep_i = '0; in_swap_i = 1'b0;
        out_ready_i = 1'b0; done = 1'b0;
        idle_cycles(3);
        check_eq("rst_valid", out_valid_o, 0);
        check_eq("rst_data", out_data_o, 0);
        check_eq("rst_last", out_last_o, 0);
        check_eq("rst_cnt", byte_cnt_o, 0);
        check_eq("rst_in_ready", in_ready_o, 0);
        rst = 1'b0;
        #1 check_eq("in_ready_pre", in_ready_o, 0);
        idle_cycles(1);
        check_eq("in_ready_post", in_ready_o, 1);

        // A55A, hi first, with one-cycle latency check.
        out_ready_i = 1'b1;
        push_word(16'hA55A, 2'b11, 1'b0);
        check_eq("lat_e", out_valid_o, 0);
        idle_cycles(1);
        check_eq("lat_e1", out_valid_o, 1);
        check_eq("first_a5", out_data_o, 8'hA5);
        check_eq("first_last", out_last_o, 0);
        measure_run(2, "a55a_run");
        drain();
        check_eq("cnt_a55a", byte_cnt_o, 2);
        push_word(16'hA55A, 2'b11, 1'b1);
        idle_cycles(1);
        check_eq("swap_first", out_data_o, 8'h5A);
        drain();
        check_eq("cnt_swap", byte_cnt_o, 4);
        push_word(16'hA55A, 2'b01, 1'b0);
        idle_cycles(1);
        check_eq("k01_data", out_data_o, 8'h5A);
        check_eq("k01_last", out_last_o, 1);
        drain();
        check_eq("cnt_k01", byte_cnt_o, 5);
        push_word(16'hA55A, 2'b00, 1'b0);
        idle_cycles(4);
        check_eq("k00_valid", out_valid_o, 0);
        check_eq("cnt_k00", byte_cnt_o, 5);

        // Backpressure: 1 word in the output stage plus 4 in the FIFO.
        out_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) push_word({4{i[3:0]}}, 2'b11, 1'b0);
        check_eq("bp_full", in_ready_o, 0);
        idle_cycles(3);
        check_eq("bp_held", in_ready_o, 0);
        check_eq("bp_data", out_data_o, 8'h11);
        out_ready_i = 1'b1;
        measure_run(10, "bp_run");
        drain();
        check_eq("bp_ready_back", in_ready_o, 1);

        // Streaming: 8 back-to-back words.
        fork
            for (int i = 0; i < 8; i++) push_word(16'($urandom), 2'b11, 1'($urandom));
            measure_run(16, "stream_run");
        join
        drain();

        // Random traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    idle_cycles($urandom_range(0, 2));
                    push_word(16'($urandom), 2'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                out_ready_i = ($urandom_range(0, 3) != 0);
            end
        join
        drain();

        // Reset after the first byte of BEEF.
        out_ready_i = 1'b0;
        push_word(16'hBEEF, 2'b11, 1'b0);
        idle_cycles(1);
        check_eq("beef_first", out_data_o, 8'hBE);
        out_ready_i = 1'b1;
        idle_cycles(1);
        check_eq("beef_second", out_data_o, 8'hEF);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", out_valid_o, 0);
        check_eq("mid_rst_data", out_data_o, 0);
        check_eq("mid_rst_cnt", byte_cnt_o, 0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(6);
        check_eq("post_rst_valid", out_valid_o, 0);
        check_eq("post_rst_cnt", byte_cnt_o, 0);

        // Counter wrap: 32767 words -> 0xFFFE, one more word -> 0x0000.
        for (int i = 0; i < 32767; i++) push_word(16'($urandom), 2'b11, 1'($urandom));
        drain();
        check_eq("cnt_fffe", byte_cnt_o, 16'hFFFE);
        push_word(16'h1234, 2'b11, 1'b0);
        drain();
        check_eq("cnt_wrap", byte_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
